emap_gather_sequencer: RTL and testbench
========================================

// Module: emap_gather_sequencer
// PURPOSE
//  Sequences the 8-wide P_Emap gather unit across a sparse-matrix row set. Per row: fetches the
//  row's multiple count, issues one gather per chunk of col_nos, waits the fixed gather latency,
//  then holds the gathered row valid until the multiply stage accepts it.
//  Replaces the free-running read_preprocess / I_am_ready loop with an explicit valid/ready FSM.
// PARAMETERS
//  NO_OF_ELEMENTS_IN_OUTPUT  8   elements gathered per chunk (informational; chunk_index scale)
//  MULTIPLES_WIDTH           32  width of per-row multiple count
//  ROW_WIDTH                 16  width of row count/index
//  CHUNK_WIDTH               16  width of chunk_index
//  READ_LATENCY              2   cycles from emap_issue cycle to valid output_row (>=1)
// PORTS
//  clk              in   1                clock, rising edge
//  rst_n            in   1                synchronous active-low reset
//  start            in   1                pulse: begin a pass over no_of_rows rows
//  no_of_rows       in   ROW_WIDTH        rows in pass, sampled on accepted start
//  mult_valid       in   1                no_of_multiples valid from index memory
//  no_of_multiples  in   MULTIPLES_WIDTH  chunks for current row
//  mult_ready       out  1                sequencer accepts no_of_multiples this cycle
//  row_index        out  ROW_WIDTH        current row (drives index/col_nos memory address)
//  emap_issue       out  1                one-cycle gather strobe to emap (read_preprocess)
//  chunk_index      out  CHUNK_WIDTH      0-based chunk selecting col_nos slice; stable ISSUE..PRESENT
//  out_valid        out  1                gathered output_row valid
//  out_last_chunk   out  1                qualifies out_valid: final chunk of row
//  out_last_row     out  1                qualifies out_valid: final row of pass
//  consumer_ready   in   1                multiply stage accepts output_row (I_am_ready)
//  busy             out  1                pass in progress
//  done             out  1                one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; all outputs 0; counters 0. Reset mid-pass aborts
//   immediately; no done pulse; outstanding emap data discarded.
//  States: IDLE, FETCH, ISSUE, WAIT, PRESENT, FINISH.
//  IDLE: start=1 -> latch no_of_rows, row_index=0; ->FETCH (busy=1 next cycle).
//   no_of_rows==0 -> FINISH directly. start while busy is ignored.
//  FETCH: mult_ready=1. On mult_valid&mult_ready latch count M, chunk_index=0.
//   M==0 -> row skipped (no issue, no output): advance row, or FINISH if last row; else ->ISSUE.
//  ISSUE: emap_issue=1 exactly one cycle; load latency counter = READ_LATENCY-1; ->WAIT.
//  WAIT: decrement each cycle; at 0 ->PRESENT. out_valid rises READ_LATENCY cycles after
//   the emap_issue cycle (issue in cycle n -> out_valid first high in cycle n+READ_LATENCY).
//  PRESENT: out_valid=1, out_last_chunk=(chunk_index==M-1), out_last_row=(last chunk &&
//   row_index==no_of_rows-1). Held until consumer_ready=1 (transfer on same edge).
//   After transfer: not last chunk -> chunk_index+1, ->ISSUE (next strobe next cycle);
//   last chunk, not last row -> row_index+1, ->FETCH; last of pass -> FINISH.
//   consumer_ready outside PRESENT is ignored.
//  FINISH: done=1 one cycle, busy=0 next cycle; ->IDLE. start during FINISH ignored.
//  Exactly one gather outstanding; emap_issue never asserted while out_valid=1.
//  Counters unsigned; M compared full MULTIPLES_WIDTH; chunk_index wraps only if M>2^CHUNK_WIDTH
//   (illegal configuration, not checked).
//  busy=1 in all states except IDLE; low in the cycle done is high? No: busy=1 through FINISH.
// TESTING
//  T1 reset: rst_n=0 during PRESENT -> next cycle all outputs 0, state IDLE, no done.
//  T2 start, rows=1, M=1, consumer_ready=1 -> emap_issue once, out_valid 2 cycles later with
//     last_chunk=last_row=1, done pulse cycle after transfer.
//  T3 rows=2, M={3,2} -> 5 issues, chunk_index 0,1,2,0,1; row_index 0,0,0,1,1; last flags correct.
//  T4 back-pressure: consumer_ready low 5 cycles in PRESENT -> out_valid held, no new emap_issue.
//  T5 rows=3, M={2,0,1} -> row 1 skipped: 3 issues total, done after row 2 transfer.
//  T6 rows=0 -> no mult_ready/issue; done one pulse; start asserted while busy -> ignored.

Source files
------------

// File: rtl/emap_gather_sequencer.sv
// Drives the 8-wide emap gather unit row by row: fetch multiple count, issue one gather per chunk,
// wait the fixed read latency, then hold the gathered row until the multiply stage takes it.
module emap_gather_sequencer #(
  parameter int NO_OF_ELEMENTS_IN_OUTPUT = 8,
  parameter int MULTIPLES_WIDTH          = 32,
  parameter int ROW_WIDTH                = 16,
  parameter int CHUNK_WIDTH              = 16,
  parameter int READ_LATENCY             = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ROW_WIDTH-1:0]       no_of_rows,
  input  logic                       mult_valid,
  input  logic [MULTIPLES_WIDTH-1:0] no_of_multiples,
  output logic                       mult_ready,
  output logic [ROW_WIDTH-1:0]       row_index,
  output logic                       emap_issue,
  output logic [CHUNK_WIDTH-1:0]     chunk_index,
  output logic                       out_valid,
  output logic                       out_last_chunk,
  output logic                       out_last_row,
  input  logic                       consumer_ready,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_PRESENT, S_FINISH
  } state_t;

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  if (NO_OF_ELEMENTS_IN_OUTPUT < 1 || READ_LATENCY < 1) begin : g_param_check
    $error("emap_gather_sequencer: illegal parameter value");
  end

  state_t                     state_q, state_d;
  logic [ROW_WIDTH-1:0]       rows_q, rows_d;
  logic [ROW_WIDTH-1:0]       row_q, row_d;
  logic [CHUNK_WIDTH-1:0]     chunk_q, chunk_d;
  logic [MULTIPLES_WIDTH-1:0] m_q, m_d;
  logic [LAT_W-1:0]           lat_q, lat_d;

  logic last_chunk, last_row;

  // Chunk count is compared at full multiple width so large M never aliases.
  assign last_chunk = (MULTIPLES_WIDTH'(chunk_q) == (m_q - MULTIPLES_WIDTH'(1)));
  assign last_row   = (row_q == (rows_q - ROW_WIDTH'(1)));

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    row_d   = row_q;
    chunk_d = chunk_q;
    m_d     = m_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = no_of_rows;
          row_d   = '0;
          chunk_d = '0;
          state_d = (no_of_rows == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (mult_valid) begin
          m_d     = no_of_multiples;
          chunk_d = '0;
          if (no_of_multiples != '0) begin
            state_d = S_ISSUE;
          end else if (last_row) begin
            state_d = S_FINISH;
          end else begin
            row_d = row_q + ROW_WIDTH'(1);
          end
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = (READ_LATENCY == 1) ? S_PRESENT : S_WAIT;
      end
      S_WAIT: begin
        // Leaving on the last count puts out_valid exactly READ_LATENCY cycles after the strobe.
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (consumer_ready) begin
          if (!last_chunk) begin
            chunk_d = chunk_q + CHUNK_WIDTH'(1);
            state_d = S_ISSUE;
          end else if (!last_row) begin
            row_d   = row_q + ROW_WIDTH'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      row_q   <= '0;
      chunk_q <= '0;
      m_q     <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      row_q   <= row_d;
      chunk_q <= chunk_d;
      m_q     <= m_d;
      lat_q   <= lat_d;
    end
  end

  assign mult_ready     = (state_q == S_FETCH);
  assign emap_issue     = (state_q == S_ISSUE);
  assign out_valid      = (state_q == S_PRESENT);
  assign out_last_chunk = out_valid && last_chunk;
  assign out_last_row   = out_valid && last_chunk && last_row;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH);
  assign row_index      = row_q;
  assign chunk_index    = chunk_q;

endmodule

// File: tb/tb_emap_gather_sequencer.sv
// Bench for emap_gather_sequencer: per-cycle vector table plus scripted multi-row passes and reset abort.
module tb_emap_gather_sequencer;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] no_of_rows;
  logic        mult_valid;
  logic [31:0] no_of_multiples;
  logic        mult_ready;
  logic [15:0] row_index;
  logic        emap_issue;
  logic [15:0] chunk_index;
  logic        out_valid;
  logic        out_last_chunk;
  logic        out_last_row;
  logic        consumer_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  emap_gather_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .no_of_rows     (no_of_rows),
    .mult_valid     (mult_valid),
    .no_of_multiples(no_of_multiples),
    .mult_ready     (mult_ready),
    .row_index      (row_index),
    .emap_issue     (emap_issue),
    .chunk_index    (chunk_index),
    .out_valid      (out_valid),
    .out_last_chunk (out_last_chunk),
    .out_last_row   (out_last_row),
    .consumer_ready (consumer_ready),
    .busy           (busy),
    .done           (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // flags = {mult_ready, emap_issue, out_valid, out_last_chunk, out_last_row, busy, done}
  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_FETCH = 7'b1000010;
  localparam logic [6:0] F_ISSUE = 7'b0100010;
  localparam logic [6:0] F_WAIT  = 7'b0000010;
  localparam logic [6:0] F_PRES  = 7'b0011110;
  localparam logic [6:0] F_FIN   = 7'b0000011;

  typedef struct {
    logic        st;
    logic [15:0] rows;
    logic        mv;
    logic [31:0] m;
    logic        cr;
    logic [6:0]  flg;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [15:0] rows, input logic mv,
                              input logic [31:0] m, input logic cr, input logic [6:0] flg);
    vec_t v;
    v.st = st; v.rows = rows; v.mv = mv; v.m = m; v.cr = cr; v.flg = flg;
    return v;
  endfunction

  function automatic logic [6:0] flags();
    return {mult_ready, emap_issue, out_valid, out_last_chunk, out_last_row, busy, done};
  endfunction

  vec_t vt[22];
  int   mq[$];

  task automatic idle_inputs();
    start = 0; no_of_rows = 0; mult_valid = 0; no_of_multiples = 0; consumer_ready = 0;
  endtask

  // Runs one pass over mq; consumer stalls on a fixed pattern; checks issue order, latency, flags, done.
  task automatic run_pass(input int rows, input string tag);
    int er[$], ec[$];
    int fi = 0, ni = 0, nd = 0, issue_cyc = -100, last_xfer = -100, cur_r = 0, cur_c = 0;
    bit pv = 0, fin = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < mq[r]; c++) begin er.push_back(r); ec.push_back(c); end
    @(negedge clk);
    start = 1; no_of_rows = 16'(rows);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      start = 0;
      mult_valid = mult_ready && (fi < mq.size());
      no_of_multiples = (fi < mq.size()) ? 32'(mq[fi]) : 32'd0;
      consumer_ready = ((cyc % 3) != 1);
      #1;
      if (mult_ready && mult_valid) begin
        chk({tag, "_fetch_row"}, 64'(row_index), 64'(fi));
        fi++;
      end
      if (emap_issue) begin
        chk({tag, "_issue_while_valid"}, 64'(out_valid), 64'd0);
        if (ni < er.size()) begin
          chk({tag, "_issue_row"}, 64'(row_index), 64'(er[ni]));
          chk({tag, "_issue_chunk"}, 64'(chunk_index), 64'(ec[ni]));
          cur_r = er[ni]; cur_c = ec[ni];
        end else begin
          chk({tag, "_extra_issue"}, 64'(ni), 64'(er.size()));
        end
        ni++;
        issue_cyc = cyc;
      end
      if (out_valid && !pv) chk({tag, "_latency"}, 64'(cyc - issue_cyc), 64'(RL));
      if (out_valid && consumer_ready) begin
        chk({tag, "_last_chunk"}, 64'(out_last_chunk), 64'(cur_c == mq[cur_r] - 1));
        chk({tag, "_last_row"}, 64'(out_last_row),
            64'((cur_c == mq[cur_r] - 1) && (cur_r == rows - 1)));
        chk({tag, "_xfer_chunk"}, 64'(chunk_index), 64'(cur_c));
        if (out_last_row) last_xfer = cyc;
      end
      pv = out_valid;
      if (done) begin
        nd++;
        fin = 1;
        chk({tag, "_done_timing"}, 64'(cyc), 64'(last_xfer + 1));
      end
    end
    if (!fin) chk({tag, "_timeout_no_done"}, 64'd0, 64'd1);
    chk({tag, "_issue_count"}, 64'(ni), 64'(er.size()));
    chk({tag, "_done_count"}, 64'(nd), 64'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vt[0]  = mk(1, 1, 0, 0, 0, F_IDLE);
    vt[1]  = mk(0, 0, 1, 1, 0, F_FETCH);
    vt[2]  = mk(0, 0, 0, 0, 0, F_ISSUE);
    vt[3]  = mk(0, 0, 0, 0, 1, F_WAIT);
    vt[4]  = mk(0, 0, 0, 0, 1, F_PRES);
    vt[5]  = mk(0, 0, 0, 0, 0, F_FIN);
    vt[6]  = mk(1, 0, 0, 0, 0, F_IDLE);
    vt[7]  = mk(1, 5, 0, 0, 0, F_FIN);
    vt[8]  = mk(0, 0, 0, 0, 0, F_IDLE);
    vt[9]  = mk(0, 0, 0, 0, 0, F_IDLE);
    vt[10] = mk(1, 1, 1, 7, 0, F_IDLE);
    vt[11] = mk(1, 3, 1, 1, 0, F_FETCH);
    vt[12] = mk(0, 0, 0, 0, 0, F_ISSUE);
    vt[13] = mk(0, 0, 0, 0, 0, F_WAIT);
    for (int i = 14; i < 19; i++) vt[i] = mk(0, 0, 0, 0, 0, F_PRES);
    vt[19] = mk(0, 0, 0, 0, 1, F_PRES);
    vt[20] = mk(0, 0, 0, 0, 0, F_FIN);
    vt[21] = mk(0, 0, 0, 0, 0, F_IDLE);

    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_flags", 64'(flags()), 64'(F_IDLE));
    chk("reset_row", 64'(row_index), 64'd0);
    chk("reset_chunk", 64'(chunk_index), 64'd0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      start = vt[i].st; no_of_rows = vt[i].rows; mult_valid = vt[i].mv;
      no_of_multiples = vt[i].m; consumer_ready = vt[i].cr;
      #1;
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vt[i].flg));
      chk($sformatf("vec%0d_idx", i), {32'd0, row_index, chunk_index}, 64'd0);
    end
    idle_inputs();

    mq = '{3, 2};
    run_pass(2, "t3");
    mq = '{2, 0, 1};
    run_pass(3, "t5");

    // Reset while presenting must abort without a done pulse.
    begin
      int w = 0;
      int nd = 0;
      @(negedge clk);
      start = 1; no_of_rows = 16'd1;
      @(negedge clk);
      start = 0;
      while (!out_valid && w < 50) begin
        mult_valid = mult_ready;
        no_of_multiples = 32'd2;
        @(negedge clk);
        w++;
      end
      mult_valid = 0;
      #1;
      chk("t1_reached_present", 64'(out_valid), 64'd1);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("t1_flags_after_reset", 64'(flags()), 64'(F_IDLE));
      chk("t1_idx_after_reset", {32'd0, row_index, chunk_index}, 64'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        if (done) nd++;
      end
      chk("t1_no_done", 64'(nd), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
